// File: rtl/axis_fp16_downsize_128to32_pkg.sv
// Shared constants and helpers for the FP16 128-to-32 AXI-Stream width converter.
package axis_fp16_downsize_128to32_pkg;

    localparam int unsigned FP16_W        = 16;
    localparam int unsigned LANES_PER_128 = 8;
    localparam int unsigned DEF_W_IN      = FP16_W * LANES_PER_128;
    localparam int unsigned DEF_W_OUT     = 32;

    // Number of narrow beats produced per wide beat.
    function automatic int unsigned width_ratio(input int unsigned w_in, input int unsigned w_out);
        return w_in / w_out;
    endfunction

    // Bit offset of FP16 lane 'lane' inside a wide beat.
    function automatic int unsigned lane_offset(input int unsigned lane);
        return lane * FP16_W;
    endfunction

    localparam int unsigned DEF_RATIO = width_ratio(DEF_W_IN, DEF_W_OUT);

endpackage

// File: rtl/axis_fp16_downsize_128to32.sv
// Serialises each wide AXI-Stream beat into W_IN/W_OUT narrow beats, low slice first,
// preserving packet framing and keeping packet/beat debug counters.
module axis_fp16_downsize_128to32 #(
    parameter int unsigned W_IN  = 128,
    parameter int unsigned W_OUT = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [W_IN-1:0]  s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic [W_OUT-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] beat_cnt
);

    import axis_fp16_downsize_128to32_pkg::*;

    localparam int unsigned RATIO = width_ratio(W_IN, W_OUT);
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    // Holding register is shifted down one slice per narrow handshake, so the
    // current slice always sits in the low W_OUT bits.
    logic [W_IN-1:0]  data_q;
    logic             full_q;
    logic             last_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] pkt_q;
    logic [CNT_W-1:0] beat_q;

    logic last_slice_c;
    logic load_c;
    logic drain_c;

    // Handshake qualifiers; a wide beat may load in the cycle the final slice drains.
    assign last_slice_c = (idx_q == IDX_LAST);
    assign s_tready     = !full_q || (m_tready && last_slice_c);
    assign load_c       = s_tvalid && s_tready;
    assign drain_c      = full_q && m_tready;

    // Output stream is a direct view of the holding state.
    assign m_tvalid = full_q;
    assign m_tdata  = data_q[W_OUT-1:0];
    assign m_tlast  = full_q && last_q && last_slice_c;
    assign pkt_cnt  = pkt_q;
    assign beat_cnt = beat_q;

    // Holding register, slice index and framing flag; a load beats a final-slice drain.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            data_q <= '0;
            full_q <= 1'b0;
            last_q <= 1'b0;
            idx_q  <= '0;
        end else if (load_c) begin
            data_q <= s_tdata;
            last_q <= s_tlast;
            idx_q  <= '0;
            full_q <= 1'b1;
        end else if (drain_c) begin
            if (last_slice_c) begin
                full_q <= 1'b0;
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
                data_q <= {W_OUT'(0), data_q[W_IN-1:W_OUT]};
            end
        end
    end

    // Debug counters: narrow beats within the current packet and completed packets.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_q  <= '0;
            beat_q <= '0;
        end else if (drain_c) begin
            if (m_tlast) begin
                beat_q <= '0;
                pkt_q  <= pkt_q + CNT_W'(1);
            end else begin
                beat_q <= beat_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_fp16_downsize_128to32.sv
// Randomised scoreboard bench for the FP16 128-to-32 AXI-Stream width converter.
module tb_axis_fp16_downsize_128to32;

    import axis_fp16_downsize_128to32_pkg::*;

    localparam int unsigned W_IN            = 128;
    localparam int unsigned W_OUT           = 32;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned RATIO           = width_ratio(W_IN, W_OUT);
    localparam int unsigned LANES_PER_SLICE = W_OUT / FP16_W;
    localparam int          CNT_MASK        = (1 << CNT_W) - 1;

    logic             aclk;
    logic             aresetn;
    logic [W_IN-1:0]  s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic             s_tlast;
    logic [W_OUT-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] beat_cnt;

    axis_fp16_downsize_128to32 #(
        .W_IN (W_IN),
        .W_OUT(W_OUT),
        .CNT_W(CNT_W)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_tdata (s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tlast (s_tlast),
        .m_tdata (m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast (m_tlast),
        .pkt_cnt (pkt_cnt),
        .beat_cnt(beat_cnt)
    );

    typedef struct {
        logic [W_OUT-1:0] d;
        logic             l;
    } nbeat_t;

    nbeat_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     exp_pkt  = 0;
    int     exp_beat = 0;
    int     hs_cnt   = 0;
    int     rdy_pct  = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference slicing built from FP16 lanes: slice k carries lanes k*2 .. k*2+1.
    function automatic logic [W_OUT-1:0] slice_of(input logic [W_IN-1:0] w, input int unsigned k);
        logic [W_OUT-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < LANES_PER_SLICE; j++) begin
            r[j*FP16_W +: FP16_W] = w[lane_offset(k*LANES_PER_SLICE + j) +: FP16_W];
        end
        return r;
    endfunction

    function automatic logic [W_IN-1:0] rand_wide();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Downstream ready generator, updated just after each rising edge.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #2;
            m_tready = ($urandom_range(0, 99) < 32'(rdy_pct));
        end
    end

    // Monitor: checks every narrow handshake against the scoreboard and the counter model.
    initial begin
        logic             prev_stall;
        logic [W_OUT-1:0] prev_d;
        logic             prev_l;
        nbeat_t           e;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                exp_q.delete();
                exp_pkt    = 0;
                exp_beat   = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 128'(m_tvalid), 128'(1'b1));
                    chk("stall_data", 128'(m_tdata), 128'(prev_d));
                    chk("stall_last", 128'(m_tlast), 128'(prev_l));
                end
                chk("pkt_cnt", 128'(pkt_cnt), 128'(exp_pkt));
                chk("beat_cnt", 128'(beat_cnt), 128'(exp_beat));
                if (m_tvalid && m_tready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
                        e.l = m_tlast;
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_tdata", 128'(m_tdata), 128'(e.d));
                        chk("m_tlast", 128'(m_tlast), 128'(e.l));
                    end
                    if (e.l) begin
                        exp_beat = 0;
                        exp_pkt  = (exp_pkt + 1) & CNT_MASK;
                    end else begin
                        exp_beat = (exp_beat + 1) & CNT_MASK;
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_d     = m_tdata;
                prev_l     = m_tlast;
            end
        end
    end

    task automatic push_expected(input logic [W_IN-1:0] d, input logic l);
        nbeat_t e;
        for (int unsigned k = 0; k < RATIO; k++) begin
            e.d = slice_of(d, k);
            e.l = l && (k == RATIO - 1);
            exp_q.push_back(e);
        end
    endtask

    // Presents one wide beat; returns just after the accepting edge with s_tvalid still high.
    task automatic send_beat(input logic [W_IN-1:0] d, input logic l, input bit auto_push);
        bit ok;
        ok       = 1'b0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge aclk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_tready_timeout: got 0 expected 1");
        end else if (auto_push) begin
            push_expected(d, l);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic s_idle();
        s_tvalid = 1'b0;
        s_tdata  = rand_wide();
        s_tlast  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(posedge aclk);
            #3;
            if (exp_q.size() == 0 && !m_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, 128'(m_tvalid), 128'(1'b0));
        chk({tag, "_m_tlast"}, 128'(m_tlast), 128'(1'b0));
        chk({tag, "_m_tdata"}, 128'(m_tdata), 128'(0));
        chk({tag, "_s_tready"}, 128'(s_tready), 128'(1'b1));
        chk({tag, "_pkt_cnt"}, 128'(pkt_cnt), 128'(0));
        chk({tag, "_beat_cnt"}, 128'(beat_cnt), 128'(0));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    // Test sequence.
    initial begin
        logic [W_IN-1:0] w;
        nbeat_t          e;
        bit              seen;
        int              base;

        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk_reset_outputs("por");
        aresetn = 1'b1;

        // 1: single beat packet with known lane values.
        rdy_pct = 100;
        @(posedge aclk);
        #1;
        w = 128'h3C00_4000_4200_4400_4500_4600_4700_4800;
        e.d = 32'h4700_4800; e.l = 1'b0; exp_q.push_back(e);
        e.d = 32'h4500_4600; e.l = 1'b0; exp_q.push_back(e);
        e.d = 32'h4200_4400; e.l = 1'b0; exp_q.push_back(e);
        e.d = 32'h3C00_4000; e.l = 1'b1; exp_q.push_back(e);
        send_beat(w, 1'b1, 1'b0);
        s_idle();
        wait_drain("t1");
        chk("t1_pkt_cnt", 128'(pkt_cnt), 128'(1));
        chk("t1_beat_cnt", 128'(beat_cnt), 128'(0));

        // 2: three back-to-back wide beats must stream 12 narrow beats without a bubble.
        fork
            begin
                for (int i = 0; i < 3; i++) send_beat(rand_wide(), 1'(i == 2), 1'b1);
                s_idle();
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    @(negedge aclk);
                    if (m_tvalid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("t2_start", 128'(seen), 128'(1'b1));
                for (int k = 0; k < 12; k++) begin
                    if (k > 0) @(negedge aclk);
                    chk("t2_no_bubble", 128'(m_tvalid), 128'(1'b1));
                    chk("t2_s_tready", 128'(s_tready), 128'((k % 4) == 3));
                    chk("t2_tlast_pos", 128'(m_tlast), 128'(k == 11));
                end
            end
        join
        wait_drain("t2");

        // 3: ten packets of ten wide beats under random backpressure.
        do_reset();
        rdy_pct = 50;
        for (int p = 0; p < 10; p++) begin
            for (int b = 0; b < 10; b++) begin
                send_beat(rand_wide(), 1'(b == 9), 1'b1);
                if ($urandom_range(0, 3) == 0) begin
                    s_idle();
                    @(posedge aclk);
                    #1;
                end
            end
        end
        s_idle();
        wait_drain("t3");
        chk("t3_pkt_cnt", 128'(pkt_cnt), 128'(10));

        // 4: long stall right after a load; output must hold and input must be blocked.
        rdy_pct = 0;
        @(posedge aclk);
        #1;
        w = rand_wide();
        send_beat(w, 1'b1, 1'b1);
        s_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            chk("t4_m_tvalid", 128'(m_tvalid), 128'(1'b1));
            chk("t4_s_tready", 128'(s_tready), 128'(1'b0));
            chk("t4_slice0", 128'(m_tdata), 128'(slice_of(w, 0)));
        end
        rdy_pct = 100;
        wait_drain("t4");

        // 5: reset after two of four slices have drained.
        w = rand_wide();
        base = hs_cnt;
        send_beat(w, 1'b1, 1'b1);
        s_idle();
        for (int t = 0; t < 50; t++) begin
            @(posedge aclk);
            if (hs_cnt >= base + 2) break;
        end
        #1;
        chk("t5_beat_cnt_pre", 128'(beat_cnt), 128'(2));
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        chk_reset_outputs("t5");
        aresetn = 1'b1;
        w = rand_wide();
        e.d = slice_of(w, 0);
        send_beat(w, 1'b1, 1'b1);
        s_idle();
        @(negedge aclk);
        chk("t5_restart_slice0", 128'(m_tdata), 128'(e.d));
        wait_drain("t5");
        chk("t5_pkt_cnt", 128'(pkt_cnt), 128'(1));

        // 6: seventeen single-beat packets wrap the 4-bit packet counter to 1.
        do_reset();
        rdy_pct = 50;
        for (int p = 0; p < 17; p++) send_beat(rand_wide(), 1'b1, 1'b1);
        s_idle();
        wait_drain("t6");
        chk("t6_pkt_wrap", 128'(pkt_cnt), 128'(1));
        chk("t6_beat_cnt", 128'(beat_cnt), 128'(0));

        repeat (2) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_fp16_downsize_128to32.md
Name: axis_fp16_downsize_128to32

Overview:
- Downstream neighbour of the 8-lane FP16 +1.0 stage.
- Consumes its 128-bit AXI-Stream beats (8 x FP16) and serialises each beat into W_IN/W_OUT narrower beats for the 32-bit DMA/S2MM path.
- Preserves packet framing: tlast goes only on the final narrow beat of the final wide beat.
- Keeps a completed-packet counter and an output-beat counter for software debug.

Parameters:
- W_IN, 128, input stream width; must be an integer multiple of W_OUT.
- W_OUT, 32, output stream width; RATIO = W_IN/W_OUT must be >= 2.
- CNT_W, 16, width of the packet and beat counters.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_tdata  in  W_IN  wide beat; FP16 lane k at bits [16k+15:16k]
- s_tvalid  in  1  wide beat valid
- s_tready  out  1  block can accept a wide beat
- s_tlast  in  1  last wide beat of packet
- m_tdata  out  W_OUT  narrow beat
- m_tvalid  out  1  narrow beat valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last narrow beat of packet
- pkt_cnt  out  CNT_W  completed packets since reset
- beat_cnt  out  CNT_W  narrow beats accepted in current packet

Behaviour:
- Reset: aresetn, synchronous, active-low; clock aclk.
- While aresetn=0, clear all state: buffer-full flag=0, sub-index idx=0, last flag=0, pkt_cnt=0, beat_cnt=0.
- Resulting outputs under reset: m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=1 (from the empty flag).
- Reset mid-packet: any buffered beat and partial count are discarded. No recovery of the truncated packet.
- State: one W_IN holding register, full flag, idx in 0..RATIO-1, stored last flag.
- m_tdata = buf[idx*W_OUT +: W_OUT]. Low slice goes first, so FP16 lanes 0,1 leave first.
- m_tvalid = full.
- m_tlast = full && last_flag && (idx == RATIO-1).
- s_tready = !full || (m_tready && idx == RATIO-1). This lets the next wide beat load in the same cycle the final slice drains, giving no bubble.
- Load: when s_tvalid && s_tready, capture buf<=s_tdata, last_flag<=s_tlast, idx<=0, full<=1.
- Latency: first slice appears on m_tdata/m_tvalid the cycle after the wide handshake.
- Sustained throughput: 1 wide beat per RATIO cycles when m_tready stays 1.
- Narrow handshake (m_tvalid && m_tready):
  - if idx<RATIO-1: idx<=idx+1;
  - else: full<=0, unless a simultaneous load occurs, in which case the load wins (full stays 1, idx<=0).
- Backpressure: while m_tready=0, m_tdata, m_tvalid, m_tlast and idx hold stable. AXI rule: valid never drops without a handshake.
- beat_cnt:
  - increments on each narrow handshake;
  - resets to 0 on the handshake that carries m_tlast;
  - wraps at 2^CNT_W.
- pkt_cnt: increments on each narrow handshake with m_tlast=1; wraps modulo 2^CNT_W.
- s_tlast is only sampled on a wide handshake. s_tdata/s_tlast are ignored when s_tvalid=0.
- Single-wide-beat packet (s_tlast=1 on first beat) produces exactly RATIO narrow beats, with m_tlast on the last.
- No data modification: bit-exact slicing, no FP arithmetic.

Decomposition:
- Shared package: FP16_W=16 and LANES_PER_128=8 constants. Also a RATIO helper function/localparam, plus lane-index-to-bit-offset helper for bench and RTL.
- Single module; no sub-module needed. The holding register and counter logic fit comfortably in one file.

Test Plan:
1. Single beat 0x3C00_4000_4200_4400_4500_4600_4700_4800 (lane7..lane0), s_tlast=1, m_tready=1 → four narrow beats in order 0x47004800, 0x45004600, 0x42004400, 0x3C004000. m_tlast only on the 4th; pkt_cnt=1; beat_cnt returns to 0.
2. Packet of 3 wide beats back-to-back, m_tready=1 → 12 consecutive narrow beats with no bubble. s_tready high only on cycles where idx=3 drains. m_tlast on the 12th only.
3. Random m_tready (50%) over 100 wide beats in 10 packets → output equals a scoreboard slice sequence, m_tdata stable while stalled, pkt_cnt=10.
4. m_tready=0 held 20 cycles after load → m_tvalid=1 steady, s_tready=0, idx frozen; releasing it resumes with no loss or duplication.
5. Assert aresetn=0 after 2 of 4 slices → next cycle m_tvalid=0 and counters 0. A new packet after reset emits from slice 0.
6. Preload pkt_cnt wrap: issue 2^CNT_W+1 single-beat packets (CNT_W=4 override: 17 packets) → pkt_cnt=1.
